// File: rtl/fetch_pkg.sv
// Shared widths, reset address and the {pc, insn} entry type for the fetch stage.
// Optional statistics counters are enabled by defining FETCH_STATS_EN.
package fetch_pkg;
    localparam int ADDR_W = 16;
    localparam int INSN_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode valid/ready channel carrying {pc, insn}.
interface fetch_if;
    logic                        out_valid;
    logic                        out_ready;
    logic [fetch_pkg::ADDR_W-1:0] out_pc;
    logic [fetch_pkg::INSN_W-1:0] out_insn;

    modport master (output out_valid, output out_pc, output out_insn, input out_ready);
    modport slave  (input out_valid, input out_pc, input out_insn, output out_ready);
endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of fetch entries; flush has priority over push and pop.
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [1:0]   count
);
    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

    // The issue throttle upstream guarantees a full FIFO is never pushed without a pop.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && !flush && count == 2'd2));
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the 1-cycle-latency imem read port, buffers words for decode.
// Define FETCH_STATS_EN to add the fetch_count / squash_count statistics ports.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_rdaddress,
    input  logic [INSN_W-1:0] imem_q,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    fetch_if.master           dec
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [15:0]       squash_count
`endif
);
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic [1:0]        count;
    logic [2:0]        occupancy;
    logic              pop;
    logic              push;
    logic              issue_en;
    fetch_entry_t      head;
    fetch_entry_t      resp;

    assign dec.out_valid  = (count != 2'd0) && !redirect_valid;
    assign pop            = dec.out_valid && dec.out_ready;
    assign push           = inflight && !redirect_valid;
    // Words that will still be held after this edge if nothing new is issued.
    assign occupancy      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue_en       = !halt && (redirect_valid || occupancy < 3'd2);
    assign imem_rdaddress = redirect_valid ? redirect_pc : fetch_pc;
    assign resp           = '{pc: req_pc, insn: imem_q};
    assign dec.out_pc     = head.pc;
    assign dec.out_insn   = head.insn;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (issue_en) begin
            req_pc   <= imem_rdaddress;
            inflight <= 1'b1;
            fetch_pc <= imem_rdaddress + ADDR_W'(1);
        end else begin
            inflight <= 1'b0;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end
        end
    end

    fetch_skid_fifo u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (resp),
        .head      (head),
        .count     (count)
    );

`ifdef FETCH_STATS_EN
    function automatic logic [15:0] sat_add_squash(input logic [15:0] acc, input logic [2:0] inc);
        logic [16:0] sum;
        sum = {1'b0, acc} + 17'(inc);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count  <= 32'd0;
            squash_count <= 16'd0;
        end else begin
            fetch_count <= fetch_count + 32'(pop);
            if (redirect_valid) begin
                squash_count <= sat_add_squash(squash_count, {1'b0, count} + {2'b00, inflight});
            end
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Scenario bench for fetch_stage: scoreboard of sequential pcs with a word[i] = i ^ 16'hA5A5 memory.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [15:0]       imem_rdaddress;
    logic [15:0]       imem_q = '0;
    logic              redirect_valid = 1'b0;
    logic [15:0]       redirect_pc = '0;
    logic              halt = 1'b0;
    logic [31:0]       fetch_count;
    logic [15:0]       squash_count;

    logic              reset2 = 1'b1;
    logic [15:0]       imem_rdaddress2;
    logic [15:0]       imem_q2 = '0;
    logic              redirect_valid2 = 1'b0;
    logic [15:0]       redirect_pc2 = '0;
    logic              halt2 = 1'b0;
    logic [31:0]       fetch_count2;
    logic [15:0]       squash_count2;

    fetch_if dif ();
    fetch_if dif2 ();

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_pc;
    int          acc;
    int          sq_exp;

    always #5 clock = ~clock;

    fetch_stage u_dut (
        .clock          (clock),
        .reset          (reset),
        .imem_rdaddress (imem_rdaddress),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .dec            (dif)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count    (fetch_count),
        .squash_count   (squash_count)
`endif
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) u_dut2 (
        .clock          (clock),
        .reset          (reset2),
        .imem_rdaddress (imem_rdaddress2),
        .imem_q         (imem_q2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .halt           (halt2),
        .dec            (dif2)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count    (fetch_count2),
        .squash_count   (squash_count2)
`endif
    );

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // Synchronous-read instruction memories.
    always @(posedge clock) begin
        imem_q  <= word_at(imem_rdaddress);
        imem_q2 <= word_at(imem_rdaddress2);
    end

    task automatic test_reset;
        reset = 1'b1; dif.out_ready = 1'b0; dif2.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", dif.out_valid); end
        n_checks++; if (dif.out_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h want 0000", dif.out_pc); end
        n_checks++; if (dif.out_insn !== 16'h0000) begin n_fail++; $display("FAIL reset_insn got %h want 0000", dif.out_insn); end
        n_checks++; if (imem_rdaddress !== 16'h0000) begin n_fail++; $display("FAIL reset_rdaddr got %h want 0000", imem_rdaddress); end
`ifdef FETCH_STATS_EN
        n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_fetch_count got %0d want 0", fetch_count); end
        n_checks++; if (squash_count !== 16'd0) begin n_fail++; $display("FAIL reset_squash_count got %0d want 0", squash_count); end
`endif
        @(negedge clock);
    endtask

    task automatic test_stream;
        reset = 1'b0; dif.out_ready = 1'b1; acc = 0; sq_exp = 0;
        #1;
        n_checks++; if (imem_rdaddress !== 16'h0000) begin n_fail++; $display("FAIL stream_first_addr got %h want 0000", imem_rdaddress); end
        exp_pc = 16'h0000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock); #1;
            n_checks++; if (dif.out_valid !== (k >= 2)) begin n_fail++; $display("FAIL stream_valid c%0d got %b want %b", k, dif.out_valid, k >= 2); end
            if (k >= 2) begin
                n_checks++; if (dif.out_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc got %h want %h", dif.out_pc, exp_pc); end
                n_checks++; if (dif.out_insn !== word_at(exp_pc)) begin n_fail++; $display("FAIL stream_insn got %h want %h", dif.out_insn, word_at(exp_pc)); end
                exp_pc++; acc++;
            end
        end
        @(negedge clock);
    endtask

    task automatic test_stall;
        dif.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            n_checks++; if (dif.out_valid !== 1'b1 || dif.out_pc !== exp_pc) begin n_fail++; $display("FAIL stall_hold got v%b %h want v1 %h", dif.out_valid, dif.out_pc, exp_pc); end
            n_checks++; if (imem_rdaddress !== exp_pc + 16'd2) begin n_fail++; $display("FAIL stall_addr got %h want %h", imem_rdaddress, exp_pc + 16'd2); end
        end
        @(negedge clock);
        dif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (dif.out_valid !== 1'b1 || dif.out_pc !== exp_pc) begin n_fail++; $display("FAIL stall_resume got v%b %h want v1 %h", dif.out_valid, dif.out_pc, exp_pc); end
            n_checks++; if (dif.out_insn !== word_at(exp_pc)) begin n_fail++; $display("FAIL stall_insn got %h want %h", dif.out_insn, word_at(exp_pc)); end
            exp_pc++; acc++;
            @(negedge clock);
        end
    endtask

    task automatic test_redirect;
        // One word on display plus one in flight are discarded.
        redirect_valid = 1'b1; redirect_pc = 16'h0100; sq_exp += 2;
        #1;
        n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got %b want 0", dif.out_valid); end
        n_checks++; if (imem_rdaddress !== 16'h0100) begin n_fail++; $display("FAIL redir_addr got %h want 0100", imem_rdaddress); end
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_gap got %b want 0", dif.out_valid); end
        exp_pc = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); #1;
            n_checks++; if (dif.out_valid !== 1'b1 || dif.out_pc !== exp_pc) begin n_fail++; $display("FAIL redir_pc got v%b %h want v1 %h", dif.out_valid, dif.out_pc, exp_pc); end
            n_checks++; if (dif.out_insn !== word_at(exp_pc)) begin n_fail++; $display("FAIL redir_insn got %h want %h", dif.out_insn, word_at(exp_pc)); end
            exp_pc++; acc++;
        end
        @(negedge clock); #1;
    endtask

    task automatic test_halt;
        int drained;
        drained = 0;
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(negedge clock); #1; end
            if (dif.out_valid) begin
                n_checks++; if (dif.out_pc !== exp_pc) begin n_fail++; $display("FAIL halt_drain_pc got %h want %h", dif.out_pc, exp_pc); end
                exp_pc++; acc++; drained++;
            end
        end
        n_checks++; if (drained != 2) begin n_fail++; $display("FAIL halt_drained got %0d want 2", drained); end
        n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_empty got %b want 0", dif.out_valid); end
        @(negedge clock);
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (dif.out_valid !== 1'b0 || imem_rdaddress !== 16'h0040) begin n_fail++; $display("FAIL halt_redir got v%b %h want v0 0040", dif.out_valid, imem_rdaddress); end
        @(negedge clock);
        halt = 1'b0;
        @(negedge clock); #1;
        n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_resume_gap got %b want 0", dif.out_valid); end
        exp_pc = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            n_checks++; if (dif.out_valid !== 1'b1 || dif.out_pc !== exp_pc) begin n_fail++; $display("FAIL halt_resume_pc got v%b %h want v1 %h", dif.out_valid, dif.out_pc, exp_pc); end
            exp_pc++; acc++;
        end
        @(negedge clock); #1;
`ifdef FETCH_STATS_EN
        n_checks++; if (fetch_count !== 32'(acc)) begin n_fail++; $display("FAIL stats_fetch_count got %0d want %0d", fetch_count, acc); end
        n_checks++; if (squash_count !== 16'(sq_exp)) begin n_fail++; $display("FAIL stats_squash_count got %0d want %0d", squash_count, sq_exp); end
`endif
    endtask

    task automatic test_reset_mid;
        dif.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_checks++; if (dif.out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_full got %b want 1", dif.out_valid); end
        reset = 1'b1;
        #1;
        n_checks++; if (dif.out_valid !== 1'b0 || dif.out_pc !== 16'h0000 || dif.out_insn !== 16'h0000) begin n_fail++; $display("FAIL rstmid_out got v%b %h %h want v0 0000 0000", dif.out_valid, dif.out_pc, dif.out_insn); end
        n_checks++; if (imem_rdaddress !== 16'h0000) begin n_fail++; $display("FAIL rstmid_addr got %h want 0000", imem_rdaddress); end
`ifdef FETCH_STATS_EN
        n_checks++; if (fetch_count !== 32'd0 || squash_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_stats got %0d %0d want 0 0", fetch_count, squash_count); end
`endif
        acc = 0; sq_exp = 0;
        @(negedge clock);
        reset = 1'b0; dif.out_ready = 1'b1;
        @(negedge clock); #1;
        n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_gap got %b want 0", dif.out_valid); end
        @(negedge clock); #1;
        n_checks++; if (dif.out_valid !== 1'b1 || dif.out_pc !== 16'h0000) begin n_fail++; $display("FAIL rstmid_refetch got v%b %h want v1 0000", dif.out_valid, dif.out_pc); end
        exp_pc = 16'h0001; acc = 1;
        @(negedge clock);
    endtask

    task automatic test_random;
        logic redir;
        int   start_acc;
        start_acc = acc;
        for (int c = 0; c < 400; c++) begin
            redir          = ($urandom % 16) == 0;
            redirect_valid = redir;
            redirect_pc    = 16'($urandom);
            halt           = ($urandom % 8) == 0;
            dif.out_ready  = ($urandom % 4) != 0;
            #1;
            if (redir) begin
                n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_redir_valid got %b want 0", dif.out_valid); end
                exp_pc = redirect_pc;
            end else if (dif.out_valid && dif.out_ready) begin
                n_checks++; if (dif.out_pc !== exp_pc || dif.out_insn !== word_at(exp_pc)) begin n_fail++; $display("FAIL rand_entry got %h/%h want %h/%h", dif.out_pc, dif.out_insn, exp_pc, word_at(exp_pc)); end
                exp_pc++; acc++;
            end
            @(negedge clock);
        end
        redirect_valid = 1'b0; halt = 1'b0; dif.out_ready = 1'b0;
        #1;
        n_checks++; if (acc - start_acc < 100) begin n_fail++; $display("FAIL rand_progress got %0d want >=100", acc - start_acc); end
`ifdef FETCH_STATS_EN
        n_checks++; if (fetch_count !== 32'(acc)) begin n_fail++; $display("FAIL rand_fetch_count got %0d want %0d", fetch_count, acc); end
`endif
        @(negedge clock);
    endtask

    task automatic test_wrap;
        logic [15:0] e;
        reset2 = 1'b0; dif2.out_ready = 1'b1;
        e = 16'hFFFE;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock); #1;
            n_checks++; if (dif2.out_valid !== (k >= 2)) begin n_fail++; $display("FAIL wrap_valid c%0d got %b want %b", k, dif2.out_valid, k >= 2); end
            if (k >= 2) begin
                n_checks++; if (dif2.out_pc !== e || dif2.out_insn !== word_at(e)) begin n_fail++; $display("FAIL wrap_entry got %h/%h want %h/%h", dif2.out_pc, dif2.out_insn, e, word_at(e)); end
                e++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the 16-bit CPU core. It owns the program counter and drives the read port of the instruction memory, which registers its read address and returns the addressed word one cycle later. It delivers {pc, instruction} pairs to decode over a valid/ready handshake. A 2-entry output buffer absorbs the memory's fixed 1-cycle latency, so decode can stall without losing words and can redirect on taken branches/jumps.

## Interface
- ADDR_W, 16, instruction address width (word addresses)
- INSN_W, 16, instruction width
- RESET_PC, 16'h0000, first address fetched after reset
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- imem_rdaddress  out  ADDR_W  read address to instruction memory (sampled by memory at posedge)
- imem_q  in  INSN_W  word for address sampled at previous posedge
- redirect_valid  in  1  discard all fetched/in-flight words, restart at redirect_pc
- redirect_pc  in  ADDR_W  redirect target
- halt  in  1  level; suppress new requests while high
- out_valid  out  1  out_pc/out_insn hold a valid entry
- out_ready  in  1  decode accepts the entry this cycle
- out_pc  out  ADDR_W  address of out_insn
- out_insn  out  INSN_W  instruction word
- fetch_count  out  32  (FETCH_STATS_EN only) entries accepted by decode
- squash_count  out  16  (FETCH_STATS_EN only) words discarded by redirect

## Operation
- State: fetch_pc, inflight (1 bit, request issued last edge), 2-entry FIFO of {pc, insn} with count 0..2, req_pc (address of in-flight request).
- pop = out_valid && out_ready. out_valid = (count != 0) && !redirect_valid.
- issue_en = !halt && (count + inflight - pop < 2); on redirect cycle issue_en = !halt.
- imem_rdaddress = redirect_valid ? redirect_pc : fetch_pc, purely combinational.
- On issue: req_pc <= imem_rdaddress, inflight <= 1, fetch_pc <= imem_rdaddress + 1 (mod 2^ADDR_W; 16'hFFFF wraps to 16'h0000). No issue: inflight <= 0; fetch_pc <= redirect_pc if redirect, else unchanged.
- Response: when inflight is set and no redirect this cycle, push {req_pc, imem_q} at the edge. Push and pop may occur in the same cycle; FIFO never overflows by construction. An overflow is an assertion failure.
- Redirect: priority over everything. FIFO cleared (count <= 0), in-flight response dropped, head not transferred even if out_ready is high.
- Halt: in-flight response still lands in the FIFO; buffered entries still drain. Deassertion resumes at fetch_pc. A redirect while halted updates fetch_pc only.
- The instruction memory write port is not driven by this block.

## Timing
- Reset values: fetch_pc=RESET_PC, imem_rdaddress=RESET_PC, inflight=0, count=0, out_valid=0, out_pc=0, out_insn=0, counters=0.
- First cycle after reset release issues RESET_PC. out_valid rises 2 cycles after release.
- Redirect in cycle N → target on imem_rdaddress in N → out_valid with out_pc=target in N+2.
- Steady state with out_ready=1: one entry per cycle, count stays at most 1.
- out_ready low for K cycles: at most 2 entries buffered, issue stops, no word lost or duplicated. Order is strictly sequential.
- Reset mid-operation: all state returns to reset values immediately (async). The pending memory response is ignored.

## Configuration
- FETCH_STATS_EN defined: fetch_count increments on each pop and wraps. squash_count increments by count + inflight on each redirect and saturates at 16'hFFFF. Both are reset to 0.
- Undefined: both ports and counters are absent; all other behaviour is identical.

## Structure
- fetch_pkg: ADDR_W, INSN_W, RESET_PC defaults; typedef fetch_entry_t {logic [ADDR_W-1:0] pc; logic [INSN_W-1:0] insn}.
- Sub-module fetch_skid_fifo: 2-entry FIFO of fetch_entry_t with push, pop, flush, count, head outputs, and async reset.

## Test plan
- Reset release, out_ready=1, memory preloaded with word[i]=i^16'hA5A5 → out_pc 0,1,2,… one per cycle from cycle 2, out_insn matching.
- out_ready low for 5 cycles mid-stream at pc 4 → stall holds pc 4; after release, 4,5,6,… with no gaps or duplicates; imem_rdaddress frozen during the stall.
- redirect_valid at pc 7 with redirect_pc=16'h0100, out_ready=1 → pcs 8/9 never appear; out_pc=16'h0100 two cycles later; squash_count incremented (if FETCH_STATS_EN).
- Start at RESET_PC=16'hFFFE → out_pc FFFE, FFFF, 0000, 0001.
- halt for 4 cycles, then redirect to 16'h0040 while halted, then release → buffered entries drain, then pc 16'h0040 onward.
- Assert reset mid-stream with count=2 → out_valid=0 immediately; refetch from RESET_PC after release.
